mdu_iterative: RTL
==================

# mdu_iterative

Parametrised iterative multiply/divide unit for the 18-447 MIPS core. It holds the architectural HI/LO registers and executes MULT/MULTU with a shift-add datapath and DIV/DIVU with a restoring divider, one bit per cycle. It raises a stall toward the pipeline while an operation is in flight. It sits beside the ALU in EX and is driven by decode's multiplier opcode field.

## Interface
- WIDTH, 32: operand, HI and LO width; must be at least 2.
- CNT_W, $clog2(WIDTH+1): iteration counter width; derived, never overridden.
- clk  in  1  clock.
- rst_b  in  1  asynchronous, active-low reset.
- mul__active  in  1  a multiplier instruction is in EX this cycle.
- mul__opcode  in  3  operation code: 0 MFHI, 1 MFLO, 2 MTHI, 3 MTLO, 4 MULT, 5 MULTU, 6 DIV, 7 DIVU.
- mul__kill  in  1  squash the in-flight op (exception or flush).
- rs_data  in  WIDTH  dividend, multiplicand, or MT source.
- rt_data  in  WIDTH  divisor or multiplier.
- mul__rd_data  out  WIDTH  MFHI/MFLO result; combinational.
- mul__busy  out  1  an operation is in flight (state != IDLE).
- mul__stall  out  1  the pipeline must hold EX this cycle; combinational.

## Operation
- States:
  - IDLE: waiting for an operation.
  - RUN: one bit per cycle, count = WIDTH..1.
  - FIX: sign correction and HI/LO writeback.
- Acceptance happens when `mul__active & ~mul__busy & ~mul__kill`:
  - MTHI/MTLO: write rs_data to HI/LO at that edge. State stays IDLE.
  - MFHI/MFLO: no state change.
  - MULT/MULTU/DIV/DIVU: latch the operands, go to RUN, load count = WIDTH.
- Signed ops (MULT, DIV) latch |rs| and |rt|, computed as unsigned WIDTH-bit magnitudes. |−2^(WIDTH−1)| = 2^(WIDTH−1). The unit records the result sign and the dividend sign.
- Multiply: a 2·WIDTH-bit product register, shift-add per cycle. In FIX, the product is negated if the signs differ.
- Divide: restoring, one quotient bit per cycle. In FIX:
  - the quotient is negated if sign(rs) ≠ sign(rt);
  - the remainder is negated if rs < 0.
- Results: LO = low word (or quotient), HI = high word (or remainder).
- Divide by zero is defined, not trapped:
  - DIVU: LO = all ones, HI = rs.
  - DIV: result is the same magnitude path with sign fixup applied.
- DIV −2^(WIDTH−1) / −1: LO = 0x80000000, HI = 0 (wraps).
- mul__stall = `mul__active & mul__busy`. Any op presented while busy is held, not accepted; this includes MT and MF ops.
- mul__rd_data:
  - HI when opcode = MFHI and not busy.
  - LO when opcode = MFLO and not busy.
  - 0 otherwise (never X).
- mul__kill:
  - In RUN or FIX, the state returns to IDLE at the next edge and HI/LO are unchanged.
  - In IDLE, it suppresses acceptance.
- Reset, including mid-operation: HI = LO = 0, state IDLE. Outputs: busy 0, stall 0, rd_data 0.

## Timing
- The accepting edge is E0. RUN covers edges E1..E_WIDTH, and FIX ends at edge E_WIDTH+1. HI/LO change at E_WIDTH+1.
- mul__busy is high from just after E0 through the cycle ending at E_WIDTH+1. That is WIDTH+1 cycles, i.e. 33 for WIDTH = 32.
- The first cycle an MF is accepted is the cycle after E_WIDTH+1, and it returns the new value.
- Back-to-back mul/div: the second op is accepted in the first cycle busy is low. There is no dead cycle beyond FIX.
- MTHI/MTLO take effect at the accepting edge. An MF in the next cycle sees the new value.
- Operand changes on rs_data/rt_data after E0 have no effect on the result.
- Kill and a new op in the same cycle while busy: kill wins and the new op is stalled this cycle. The new op is accepted next cycle if still presented without kill.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, then MFHI/MFLO:
  - busy for exactly 33 cycles;
  - HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- Divide results:
  - DIVU 100 / 7 → LO = 14, HI = 2.
  - DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
  - DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5.
- MFLO held active from the cycle after a MULT accept:
  - stall is high for 33 cycles and rd_data reads 0 meanwhile;
  - in the first non-busy cycle, stall is low and rd_data equals the new LO.
- MTHI 0x12345678, then MFHI the next cycle → 0x12345678. MTLO presented while busy is stalled, and LO is unchanged until accepted.
- Abort cases:
  - kill asserted 10 cycles into a DIV: busy falls the next cycle and HI/LO keep their prior values;
  - rst_b pulsed low mid-MULT: HI = LO = 0 and busy = 0 immediately, with no writeback after release.

Source files
------------

// File: rtl/mdu_iterative_if.sv
// Pipeline-side bundle for the iterative multiply/divide unit.
// The pipeline drives through the master modport and the unit uses slave.
interface mdu_iterative_if #(
    parameter int WIDTH = 32
);
    logic             mul__active;
    logic [2:0]       mul__opcode;
    logic             mul__kill;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] mul__rd_data;
    logic             mul__busy;
    logic             mul__stall;

    modport master (
        output mul__active, mul__opcode, mul__kill, rs_data, rt_data,
        input  mul__rd_data, mul__busy, mul__stall
    );

    modport slave (
        input  mul__active, mul__opcode, mul__kill, rs_data, rt_data,
        output mul__rd_data, mul__busy, mul__stall
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative MIPS multiply/divide unit: holds HI/LO, shift-add multiply and
// restoring divide at one bit per cycle, with a stall toward the pipeline.
//
// state | meaning
// IDLE  | waiting for an operation; MT/MF handled here
// RUN   | one multiply/divide bit per cycle, count WIDTH..1
// FIX   | sign correction and HI/LO writeback
module mdu_iterative #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic            clk,
    input logic            rst_b,
    mdu_iterative_if.slave mdu
);
    localparam logic [2:0] OP_MFHI  = 3'd0;
    localparam logic [2:0] OP_MFLO  = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd2;
    localparam logic [2:0] OP_MTLO  = 3'd3;
    localparam logic [2:0] OP_MULT  = 3'd4;
    localparam logic [2:0] OP_MULTU = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_DIVU  = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               is_div_q, neg_res_q, neg_rem_q;

    logic               busy, accept, rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;

    assign busy   = (state_q != IDLE);
    assign accept = mdu.mul__active & ~busy & ~mdu.mul__kill;
    // Opcode bit 0 clear marks the signed variants (MULT, DIV).
    assign rs_neg = ~mdu.mul__opcode[0] & mdu.rs_data[WIDTH-1];
    assign rt_neg = ~mdu.mul__opcode[0] & mdu.rt_data[WIDTH-1];
    assign rs_mag = rs_neg ? -mdu.rs_data : mdu.rs_data;
    assign rt_mag = rt_neg ? -mdu.rt_data : mdu.rt_data;

    assign mdu.mul__busy  = busy;
    assign mdu.mul__stall = mdu.mul__active & busy;

    always_comb begin
        mdu.mul__rd_data = '0;
        if (!busy) begin
            case (mdu.mul__opcode)
                OP_MFHI: mdu.mul__rd_data = hi_q;
                OP_MFLO: mdu.mul__rd_data = lo_q;
                default: mdu.mul__rd_data = '0;
            endcase
        end
    end

    // acc_q is {HI, LO} for multiply and {remainder, quotient} for divide.
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] step_nxt, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, hi_fix, lo_fix;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_sub = rem_sh[WIDTH-1:0] - opb_q;
        if (is_div_q) begin
            if (rem_sh >= {1'b0, opb_q})
                step_nxt = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
            else
                step_nxt = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            step_nxt = {mul_sum, acc_q[WIDTH-1:1]};
        end
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        hi_fix   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && mdu.mul__opcode[2]) state_d = RUN;
            RUN: begin
                if (mdu.mul__kill)               state_d = IDLE;
                else if (cnt_q == CNT_W'(1))     state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    case (mdu.mul__opcode)
                        OP_MTHI: hi_q <= mdu.rs_data;
                        OP_MTLO: lo_q <= mdu.rs_data;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            acc_q     <= {{WIDTH{1'b0}}, (mdu.mul__opcode[1] ? rs_mag : rt_mag)};
                            opb_q     <= mdu.mul__opcode[1] ? rt_mag : rs_mag;
                            cnt_q     <= CNT_W'(WIDTH);
                            is_div_q  <= mdu.mul__opcode[1];
                            neg_res_q <= rs_neg ^ rt_neg;
                            neg_rem_q <= rs_neg;
                        end
                        default: ;
                    endcase
                end
                RUN: if (!mdu.mul__kill) begin
                    acc_q <= step_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                FIX: if (!mdu.mul__kill) begin
                    hi_q <= hi_fix;
                    lo_q <= lo_fix;
                end
                default: ;
            endcase
        end
    end
endmodule
